// File: rtl/pcs_rx_32b_block_lock.sv
// rtl/pcs_rx_32b_block_lock.sv - 66b sync-header block lock FSM with BER monitor
// Drives PMA gearbox slips until lock, then tracks header error rate per BER window.
module pcs_rx_32b_block_lock #(
  parameter int LOCK_CNT  = 64,
  parameter int INVLD_MAX = 16,
  parameter int SLIP_WAIT = 8,
  parameter int BER_TIMER = 40283
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hdr_valid,
  input  logic [1:0] hdr,
  output logic       pma_slip,
  output logic       pma_sync,
  output logic       hi_ber,
  output logic [4:0] ber_cnt
);
  localparam int CW = $clog2(LOCK_CNT) + 1;
  localparam int WW = $clog2(SLIP_WAIT + 1) + 1;
  localparam int TW = $clog2(BER_TIMER + 1);

  localparam logic [0:0] ST_COUNT = 1'b0;
  localparam logic [0:0] ST_WAIT  = 1'b1;

  localparam logic [CW-1:0] SH_LAST   = CW'(LOCK_CNT);
  localparam logic [CW-1:0] INV_LIMIT = CW'(INVLD_MAX);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT - 1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(BER_TIMER - 1);
  localparam logic [4:0]    BER_MAX   = 5'(INVLD_MAX);

  logic [0:0]    r_state;
  logic [CW-1:0] r_sh_cnt;
  logic [CW-1:0] r_sh_invld_cnt;
  logic [WW-1:0] r_wait_cnt;
  logic [TW-1:0] r_ber_tmr;
  logic [4:0]    r_ber_cnt;
  logic          r_pma_slip;
  logic          r_pma_sync;
  logic          r_hi_ber;

  logic          w_bad;
  logic          w_hdr;
  logic          w_slip;
  logic          w_win_end;
  logic          w_tmr_wrap;
  logic [CW-1:0] w_sh_cnt_nxt;
  logic [CW-1:0] w_invld_nxt;
  logic [4:0]    w_ber_nxt;

  assign w_bad        = hdr_valid && (hdr == 2'b00 || hdr == 2'b11);
  assign w_hdr        = (r_state == ST_COUNT) && hdr_valid;
  assign w_sh_cnt_nxt = r_sh_cnt + CW'(1);
  assign w_invld_nxt  = r_sh_invld_cnt + CW'(w_bad);
  // Unlocked: any bad header slips; locked: only a full budget of bad headers does.
  assign w_slip       = w_hdr && w_bad && (!r_pma_sync || (w_invld_nxt >= INV_LIMIT));
  assign w_win_end    = w_hdr && (w_sh_cnt_nxt == SH_LAST);
  assign w_ber_nxt    = (w_bad && (r_ber_cnt < BER_MAX)) ? r_ber_cnt + 5'd1 : r_ber_cnt;
  assign w_tmr_wrap   = (r_ber_tmr == TMR_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= ST_COUNT;
      r_sh_cnt       <= '0;
      r_sh_invld_cnt <= '0;
      r_wait_cnt     <= '0;
      r_pma_slip     <= 1'b0;
      r_pma_sync     <= 1'b0;
    end else begin
      r_pma_slip <= 1'b0;
      case (r_state)
        ST_COUNT: begin
          if (w_slip) begin
            r_pma_slip     <= 1'b1;
            r_pma_sync     <= 1'b0;
            r_sh_cnt       <= '0;
            r_sh_invld_cnt <= '0;
            r_wait_cnt     <= '0;
            r_state        <= ST_WAIT;
          end else if (w_win_end) begin
            if (w_invld_nxt == '0) begin
              r_pma_sync <= 1'b1;
            end
            r_sh_cnt       <= '0;
            r_sh_invld_cnt <= '0;
          end else if (w_hdr) begin
            r_sh_cnt       <= w_sh_cnt_nxt;
            r_sh_invld_cnt <= w_invld_nxt;
          end
        end
        default: begin
          // Gearbox settling: headers are not trusted until the wait expires.
          if (r_wait_cnt == WAIT_LAST) begin
            r_wait_cnt <= '0;
            r_state    <= ST_COUNT;
          end else begin
            r_wait_cnt <= r_wait_cnt + WW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ber_tmr <= '0;
      r_ber_cnt <= '0;
      r_hi_ber  <= 1'b0;
    end else if (!r_pma_sync) begin
      r_ber_tmr <= '0;
      r_ber_cnt <= '0;
    end else if (w_tmr_wrap) begin
      // The wrap cycle's header still counts toward the window being closed.
      r_ber_tmr <= '0;
      r_ber_cnt <= '0;
      r_hi_ber  <= (w_ber_nxt >= BER_MAX);
    end else begin
      r_ber_tmr <= r_ber_tmr + TW'(1);
      r_ber_cnt <= w_ber_nxt;
      if (w_ber_nxt == BER_MAX) begin
        r_hi_ber <= 1'b1;
      end
    end
  end

  assign pma_slip = r_pma_slip;
  assign pma_sync = r_pma_sync;
  assign hi_ber   = r_hi_ber;
  assign ber_cnt  = r_ber_cnt;

endmodule

// File: tb/tb_pcs_rx_32b_block_lock.sv
// tb/tb_pcs_rx_32b_block_lock.sv - self-checking bench for pcs_rx_32b_block_lock
// Directed lock/slip/BER scenarios followed by randomized headers against a reference model.
module tb_pcs_rx_32b_block_lock;
  localparam int LOCK_CNT  = 64;
  localparam int INVLD_MAX = 16;
  localparam int SLIP_WAIT = 8;
  localparam int BER_TIMER = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       hdr_valid = 1'b0;
  logic [1:0] hdr = 2'b01;
  logic       pma_slip;
  logic       pma_sync;
  logic       hi_ber;
  logic [4:0] ber_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: settle is a countdown of ignored cycles, age is cycles since lock mod window.
  int m_slip, m_sync, m_hiber, m_bercnt, m_settle, m_hdrs, m_bad, m_age;
  bit alt = 1'b0;

  pcs_rx_32b_block_lock #(
    .LOCK_CNT (LOCK_CNT),
    .INVLD_MAX(INVLD_MAX),
    .SLIP_WAIT(SLIP_WAIT),
    .BER_TIMER(BER_TIMER)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .hdr_valid(hdr_valid),
    .hdr      (hdr),
    .pma_slip (pma_slip),
    .pma_sync (pma_sync),
    .hi_ber   (hi_ber),
    .ber_cnt  (ber_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit bad;
    int b, hdrs, badc, n_sync, n_slip;
    if (!rst) begin
      m_slip = 0; m_sync = 0; m_hiber = 0; m_bercnt = 0;
      m_settle = 0; m_hdrs = 0; m_bad = 0; m_age = 0;
      return;
    end
    bad    = hdr_valid && (hdr == 2'b00 || hdr == 2'b11);
    n_sync = m_sync;
    n_slip = 0;
    if (m_sync != 0) begin
      b = m_bercnt + (bad ? 1 : 0);
      if (b > INVLD_MAX) b = INVLD_MAX;
      if (m_age == BER_TIMER - 1) begin
        m_hiber  = (b >= INVLD_MAX) ? 1 : 0;
        m_bercnt = 0;
        m_age    = 0;
      end else begin
        if (b == INVLD_MAX) m_hiber = 1;
        m_bercnt = b;
        m_age++;
      end
    end else begin
      m_bercnt = 0;
      m_age    = 0;
    end
    if (m_settle > 0) begin
      m_settle--;
    end else if (hdr_valid) begin
      hdrs = m_hdrs + 1;
      badc = m_bad + (bad ? 1 : 0);
      if (bad && (m_sync == 0 || badc >= INVLD_MAX)) begin
        n_slip = 1; n_sync = 0; m_hdrs = 0; m_bad = 0; m_settle = SLIP_WAIT;
      end else if (hdrs == LOCK_CNT) begin
        if (badc == 0) n_sync = 1;
        m_hdrs = 0; m_bad = 0;
      end else begin
        m_hdrs = hdrs; m_bad = badc;
      end
    end
    m_slip = n_slip;
    m_sync = n_sync;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_eq("pma_slip", pma_slip, m_slip);
    check_eq("pma_sync", pma_sync, m_sync);
    check_eq("hi_ber", hi_ber, m_hiber);
    check_eq("ber_cnt", ber_cnt, m_bercnt);
  endtask

  task automatic send(input bit v, input logic [1:0] h);
    hdr_valid = v;
    hdr       = h;
    step();
  endtask

  task automatic send_good();
    alt = ~alt;
    send(1'b1, alt ? 2'b01 : 2'b10);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    hdr_valid = 1'b1;
    hdr = 2'b11;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic lock_up();
    repeat (LOCK_CNT - 1) send_good();
    check_eq("lock_before_last", pma_sync, 0);
    send_good();
    check_eq("lock_after_last", pma_sync, 1);
  endtask

  function automatic bit ber_bad(input int k);
    return (k >= 56 && k <= 63) || (k >= 100 && k <= 107) ||
           (k >= 240 && k <= 247) || (k >= 260 && k <= 267);
  endfunction

  task automatic ber_run(input bit abort);
    int last;
    last = abort ? 267 : 399;
    do_reset();
    lock_up();
    for (int k = 0; k <= last; k++) begin
      if (ber_bad(k)) send(1'b1, 2'b11);
      else send_good();
      if (k == 199) check_eq("ber_split_no_hi", hi_ber, 0);
      if (k == 266) begin
        check_eq("ber_15_hi", hi_ber, 0);
        check_eq("ber_15_cnt", ber_cnt, 15);
      end
      if (k == 267) begin
        check_eq("ber_16_hi", hi_ber, 1);
        check_eq("ber_16_cnt", ber_cnt, 16);
        check_eq("ber_16_sync", pma_sync, 1);
      end
      if (k == 299) begin
        check_eq("ber_wrap_hold", hi_ber, 1);
        check_eq("ber_wrap_cnt", ber_cnt, 0);
      end
      if (k == 398) check_eq("ber_clean_pre", hi_ber, 1);
      if (k == 399) check_eq("ber_clean_clear", hi_ber, 0);
    end
    if (abort) begin
      repeat (7) send(1'b1, 2'b11);
      check_eq("ber_abort_noslip", pma_slip, 0);
      send(1'b1, 2'b11);
      check_eq("ber_abort_slip", pma_slip, 1);
      check_eq("ber_abort_sync", pma_sync, 0);
      check_eq("ber_abort_hi_hold", hi_ber, 1);
      send_good();
      check_eq("wait_hi_hold", hi_ber, 1);
      rst = 1'b0;
      send_good();
      check_eq("rst_wait_slip", pma_slip, 0);
      check_eq("rst_wait_sync", pma_sync, 0);
      check_eq("rst_wait_hi", hi_ber, 0);
      check_eq("rst_wait_cnt", ber_cnt, 0);
      rst = 1'b1;
      lock_up();
    end
  endtask

  initial begin
    int err_div;
    int v_thr;
    bit v;
    bit bad;
    do_reset();
    check_eq("rst_slip", pma_slip, 0);
    check_eq("rst_sync", pma_sync, 0);
    check_eq("rst_hi", hi_ber, 0);
    check_eq("rst_cnt", ber_cnt, 0);

    lock_up();

    do_reset();
    repeat (9) send_good();
    send(1'b1, 2'b11);
    check_eq("unlocked_slip", pma_slip, 1);
    for (int i = 0; i < SLIP_WAIT; i++) begin
      if (i == 3) send(1'b1, 2'b00);
      else send_good();
      check_eq("wait_no_slip", pma_slip, 0);
    end
    lock_up();

    for (int i = 0; i < LOCK_CNT; i++) begin
      if ((i % 4) == 1 && i < 60) send(1'b1, 2'b11);
      else send_good();
    end
    check_eq("inv15_sync", pma_sync, 1);
    check_eq("inv15_noslip", pma_slip, 0);
    for (int i = 0; i < INVLD_MAX; i++) begin
      send(1'b1, 2'b00);
      if (i == INVLD_MAX - 2) check_eq("inv15b_sync", pma_sync, 1);
    end
    check_eq("inv16_slip", pma_slip, 1);
    check_eq("inv16_sync", pma_sync, 0);
    send_good();
    check_eq("slip_one_cycle", pma_slip, 0);
    repeat (SLIP_WAIT - 1) send_good();
    lock_up();

    for (int i = 0; i < LOCK_CNT; i++) begin
      if (i >= LOCK_CNT - INVLD_MAX) send(1'b1, 2'b11);
      else send_good();
      if (i == LOCK_CNT - 2) check_eq("coinc_pre_sync", pma_sync, 1);
    end
    check_eq("coinc_slip", pma_slip, 1);
    check_eq("coinc_sync", pma_sync, 0);
    repeat (SLIP_WAIT) send_good();

    ber_run(1'b0);
    ber_run(1'b1);

    for (int seg = 0; seg < 30 && n_fail < 50; seg++) begin
      case (seg % 4)
        0: err_div = 0;
        1: err_div = 500;
        2: err_div = 60;
        default: err_div = 4;
      endcase
      v_thr = ((seg / 4) % 2 == 0) ? 10 : 8;
      for (int c = 0; c < 1000; c++) begin
        rst = ($urandom_range(0, 1999) != 0);
        v   = ($urandom_range(0, 9) < v_thr);
        bad = (err_div != 0) && ($urandom_range(0, err_div - 1) == 0);
        if (bad) send(v, ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11);
        else     send(v, ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10);
      end
    end
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcs_rx_32b_block_lock.md
PCS_RX_32B_BLOCK_LOCK -- requirements
Module: pcs_rx_32b_block_lock

Interface
REQ-001 Parameter LOCK_CNT, default 64: sync headers per lock test window.
REQ-002 Parameter INVLD_MAX, default 16: invalid headers per window that force loss of lock.
REQ-003 Parameter SLIP_WAIT, default 8: clk cycles headers are ignored after a slip, for gearbox settling.
REQ-004 Parameter BER_TIMER, default 40283: clk cycles per 125 us BER window at 322.27 MHz.
REQ-005 clk  in  1  sole clock, the 32b PMA RX clock.
REQ-006 rst  in  1  reset, synchronous and active-low.
REQ-007 hdr_valid  in  1  hdr carries a new 66b sync header this cycle.
REQ-008 hdr  in  2  sync header; 2'b01 or 2'b10 is valid, 2'b00 or 2'b11 is invalid.
REQ-009 pma_slip  out  1  one-cycle pulse requesting a one-bit slip from the PMA gearbox.
REQ-010 pma_sync  out  1  block_lock, registered.
REQ-011 hi_ber  out  1  high bit-error-rate indication, registered.
REQ-012 ber_cnt  out  5  invalid headers in the current BER window, saturating at INVLD_MAX.

Function
REQ-013 FSM states: COUNT and WAIT. Reset enters COUNT with sh_cnt=0, sh_invld_cnt=0 and wait_cnt=0.
REQ-014 In COUNT, each hdr_valid cycle increments sh_cnt; if hdr is invalid, it also increments sh_invld_cnt.
REQ-015 Slip condition, checked on the updated counts of the current header:
- pma_sync=0 and the header is invalid; or
- pma_sync=1 and sh_invld_cnt reaches INVLD_MAX.
REQ-016 On the slip condition, the next cycle: pma_slip=1 for exactly one cycle, pma_sync=0, sh_cnt and sh_invld_cnt cleared, state=WAIT.
REQ-017 Window end (sh_cnt reaches LOCK_CNT) with sh_invld_cnt=0: pma_sync=1 the next cycle; counters cleared.
REQ-018 Window end with pma_sync=1 and 0<sh_invld_cnt<INVLD_MAX: pma_sync stays 1; counters cleared.
REQ-019 If the slip condition and window end coincide, slip wins.
REQ-020 WAIT:
- hdr_valid is ignored.
- wait_cnt counts SLIP_WAIT cycles, then the FSM returns to COUNT.
- No further pma_slip can be issued in WAIT, so minimum pma_slip spacing is SLIP_WAIT+1 cycles.
REQ-021 Latency: pma_sync and pma_slip change exactly one clk after the deciding hdr_valid cycle.
REQ-022 BER timer, counting:
- Free-running counter of clk cycles, 0..BER_TIMER-1, wrapping to 0.
- Runs only while pma_sync=1.
- Held at 0 and ber_cnt cleared while pma_sync=0.
REQ-023 BER timer, invalid headers and hi_ber set:
- While pma_sync=1, each invalid header increments ber_cnt, saturating at INVLD_MAX.
- hi_ber=1 the cycle after ber_cnt reaches INVLD_MAX.
REQ-024 On timer wrap:
- If the count including the wrap cycle's header is below INVLD_MAX, hi_ber=0.
- ber_cnt restarts at 0; the wrap cycle's header belongs to the closing window.
REQ-025 On loss of lock, hi_ber holds its value until the next window evaluation after relock.
REQ-026 hdr is ignored when hdr_valid=0; sh_cnt/sh_invld_cnt widths are clog2(LOCK_CNT)+1 with no wrap beyond LOCK_CNT.

Reset
REQ-027 When rst=0 at a clk edge, the next cycle shows:
- pma_slip=0, pma_sync=0, hi_ber=0, ber_cnt=0;
- FSM in COUNT, all counters 0.
REQ-028 Reset mid-WAIT or mid-window aborts the operation; any pending pma_slip is suppressed.

Verification
REQ-029 From reset, 64 valid headers (alternating 01/10, hdr_valid=1 every cycle) -> pma_sync=1 one cycle after the 64th header, pma_slip never asserted.
REQ-030 Unlocked, header 2'b11 at header 10 -> pma_slip pulse one cycle later, then 8 cycles ignoring headers; a 2'b00 in WAIT is ignored; after 64 further valid headers pma_sync=1.
REQ-031 Locked, 15 invalid headers among 64 -> pma_sync stays 1, no slip; 16 invalid within one window -> pma_slip pulse and pma_sync=0 one cycle after the 16th.
REQ-032 Locked, 16th invalid header coincident with the 64th header of the window -> slip taken, pma_sync=0.
REQ-033 Locked, BER_TIMER=100, 16 invalid headers spread across two windows -> no hi_ber; 16 invalid headers within one window -> hi_ber=1, ber_cnt=16, and hi_ber clears after the next clean window.
REQ-034 rst=0 asserted while locked with hi_ber=1 and in WAIT -> all outputs 0 next cycle; relock requires 64 fresh valid headers.
